// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: pin glitch filters, 11-bit frame deframer and E0/F0 prefix folding.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_scancode_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DATA,
   output logic [7:0] oScanCode,
   output logic       oBreak,
   output logic       oExtended,
   output logic       oValid,
   output logic       oFrameError
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   localparam int              TO_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      EXT_PREFIX = 8'hE0;
   localparam logic [7:0]      BRK_PREFIX = 8'hF0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_t;

   // With the check disabled the parity bit is still captured but never vetoes a frame.
   function automatic logic frameGood(input logic stopBit, input logic [7:0] data,
                                      input logic parity);
      return stopBit && (!PARITY_CHECK || (^{data, parity}));
   endfunction

   logic [FILTER_LEN-1:0] clkShift;
   logic [FILTER_LEN-1:0] dataShift;
   logic                  clkFilt;
   logic                  dataFilt;
   logic                  clkFiltPrev;
   logic                  fall;

   rxState_t              state, stateNext;
   logic [7:0]            shiftReg, shiftNext;
   logic [2:0]            bitCount, bitCountNext;
   logic                  parityBit, parityNext;
   logic [TO_W-1:0]       toCount, toCountNext;
   logic                  timeout;
   logic                  extPend, extPendNext;
   logic                  brkPend, brkPendNext;
   logic [7:0]            scanNext;
   logic                  breakNext;
   logic                  extendedNext;
   logic                  validNext;
   logic                  errorNext;

   // Filter stage: a level only changes once the pin has been stable for FILTER_LEN samples
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         clkShift    <= '1;
         dataShift   <= '1;
         clkFilt     <= 1'b1;
         dataFilt    <= 1'b1;
         clkFiltPrev <= 1'b1;
      end else begin
         clkShift  <= {clkShift[FILTER_LEN-2:0], iPS2_CLK};
         dataShift <= {dataShift[FILTER_LEN-2:0], iPS2_DATA};
         if (&clkShift)
            clkFilt <= 1'b1;
         else if (~|clkShift)
            clkFilt <= 1'b0;
         if (&dataShift)
            dataFilt <= 1'b1;
         else if (~|dataShift)
            dataFilt <= 1'b0;
         clkFiltPrev <= clkFilt;
      end
   end

   assign fall = clkFiltPrev & ~clkFilt;

   // Deframer and byte handler register stage
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         shiftReg    <= '0;
         bitCount    <= '0;
         parityBit   <= 1'b0;
         toCount     <= '0;
         extPend     <= 1'b0;
         brkPend     <= 1'b0;
         oScanCode   <= 8'h00;
         oBreak      <= 1'b0;
         oExtended   <= 1'b0;
         oValid      <= 1'b0;
         oFrameError <= 1'b0;
      end else begin
         state       <= stateNext;
         shiftReg    <= shiftNext;
         bitCount    <= bitCountNext;
         parityBit   <= parityNext;
         toCount     <= toCountNext;
         extPend     <= extPendNext;
         brkPend     <= brkPendNext;
         oScanCode   <= scanNext;
         oBreak      <= breakNext;
         oExtended   <= extendedNext;
         oValid      <= validNext;
         oFrameError <= errorNext;
      end
   end

   always_comb begin
      stateNext    = state;
      shiftNext    = shiftReg;
      bitCountNext = bitCount;
      parityNext   = parityBit;
      extPendNext  = extPend;
      brkPendNext  = brkPend;
      scanNext     = oScanCode;
      breakNext    = oBreak;
      extendedNext = oExtended;
      validNext    = 1'b0;
      errorNext    = 1'b0;

      // A fall arriving on the last allowed cycle still counts, so it beats the timeout.
      timeout = (state != IDLE) && !fall && (toCount == TO_LAST);
      if (state == IDLE || fall)
         toCountNext = '0;
      else
         toCountNext = toCount + 1'b1;

      if (timeout) begin
         stateNext   = IDLE;
         errorNext   = 1'b1;
         extPendNext = 1'b0;
         brkPendNext = 1'b0;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dataFilt) begin
                  stateNext    = DATA;
                  bitCountNext = '0;
               end
            end
            DATA: begin
               shiftNext    = {dataFilt, shiftReg[7:1]};
               bitCountNext = bitCount + 1'b1;
               if (bitCount == 3'd7)
                  stateNext = PARITY;
            end
            PARITY: begin
               parityNext = dataFilt;
               stateNext  = STOP;
            end
            STOP: begin
               stateNext = IDLE;
               if (!frameGood(dataFilt, shiftReg, parityBit)) begin
                  errorNext   = 1'b1;
                  extPendNext = 1'b0;
                  brkPendNext = 1'b0;
               end else if (shiftReg == EXT_PREFIX) begin
                  extPendNext = 1'b1;
               end else if (shiftReg == BRK_PREFIX) begin
                  brkPendNext = 1'b1;
               end else begin
                  scanNext     = shiftReg;
                  breakNext    = brkPend;
                  extendedNext = extPend;
                  validNext    = 1'b1;
                  extPendNext  = 1'b0;
                  brkPendNext  = 1'b0;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomised PS/2 frame bench for ps2_scancode_receiver with an event-queue reference model.
`timescale 1ns/1ps
module tb_ps2_scancode_receiver;
   localparam int FL   = 8;
   localparam int TO   = 300;
   localparam int HALF = 30;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [7:0] oScanCode;
   logic       oBreak, oExtended, oValid, oFrameError;

   ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Reset(Reset), .iPS2_CLK(ps2Clk), .iPS2_DATA(ps2Data),
      .oScanCode(oScanCode), .oBreak(oBreak), .oExtended(oExtended),
      .oValid(oValid), .oFrameError(oFrameError));

   always #20 Clock = ~Clock;

   typedef struct {
      int         cyc;
      bit         isErr;
      logic [7:0] code;
      bit         brk;
      bit         ext;
   } ev_t;

   ev_t        expQ[$];
   int         cycle = 0, checks = 0, errors = 0;
   int         nValid = 0, nErr = 0, lastLow = 0, lastValidCyc = 0;
   logic [7:0] mCode = 8'h00;
   bit         mBrk = 0, mExt = 0, pendE = 0, pendF = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic pushEv(input int cyc, input bit isErr, input logic [7:0] code,
                         input bit brk, input bit ext);
      ev_t e;
      e.cyc = cyc; e.isErr = isErr; e.code = code; e.brk = brk; e.ext = ext;
      expQ.push_back(e);
   endtask

   // Key-event rules applied to one complete frame as the device sent it.
   task automatic modelFrame(input logic [7:0] b, input logic par, input logic stop, input int cyc);
      bit good;
      good = stop && (!PCHK || (^{b, par}));
      if (!good) begin
         pushEv(cyc, 1, 8'h00, 0, 0);
         pendE = 0; pendF = 0;
      end else if (b == 8'hE0) begin
         pendE = 1;
      end else if (b == 8'hF0) begin
         pendF = 1;
      end else begin
         pushEv(cyc, 0, b, pendF, pendE);
         pendE = 0; pendF = 0;
      end
   endtask

   // Bit i of fr goes out on the i-th PS/2 clock low; data changes while the clock is high.
   task automatic sendBits(input logic [10:0] fr, input int nbits, input bit glitch, input bit track);
      for (int i = 0; i < nbits; i++) begin
         ps2Data = fr[i];
         if (glitch && (i == 3 || i == 6)) begin
            waitCyc(HALF / 2);
            ps2Clk = 1'b0;
            waitCyc(3);
            ps2Clk = 1'b1;
            waitCyc(HALF - HALF / 2 - 3);
         end else begin
            waitCyc(HALF);
         end
         ps2Clk  = 1'b0;
         lastLow = cycle;
         if (track && i == 10)
            modelFrame(fr[8:1], fr[9], fr[10], cycle + FL + 2);
         else if (track && i == nbits - 1 && nbits < 11) begin
            pushEv(cycle + FL + 2 + TO, 1, 8'h00, 0, 0);
            pendE = 0; pendF = 0;
         end
         waitCyc(HALF);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                            input int nbits, input bit glitch);
      logic par;
      par = (~^b) ^ badPar;
      sendBits({~badStop, par, b, 1'b0}, nbits, glitch, 1'b1);
      if (nbits < 11) waitCyc(2 * TO + 200);
      else            waitCyc(40);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         @(negedge Clock);
         n++;
      end
      chk("queue_drain", expQ.size(), 0);
   endtask

   // Per-cycle comparison against the model's expected pulses and held outputs
   initial begin
      ev_t ev;
      bit  expV, expE;
      forever begin
         @(posedge Clock);
         #1;
         cycle++;
         expV = 0; expE = 0;
         if (expQ.size() > 0 && expQ[0].cyc == cycle) begin
            ev = expQ.pop_front();
            expE = ev.isErr;
            expV = !ev.isErr;
            if (expV) begin
               mCode = ev.code; mBrk = ev.brk; mExt = ev.ext;
            end
         end
         chk("oValid", oValid, expV);
         chk("oFrameError", oFrameError, expE);
         chk("oScanCode", oScanCode, mCode);
         chk("oBreak", oBreak, mBrk);
         chk("oExtended", oExtended, mExt);
         if (oValid === 1'b1) begin nValid++; lastValidCyc = cycle; end
         if (oFrameError === 1'b1) nErr++;
      end
   end

   initial begin
      repeat (120000) @(posedge Clock);
      $display("FAIL watchdog: cycle %0d reached limit %0d", cycle, 120000);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0, e0, sel, kind, nb;
      logic [7:0] b;
      #5 Reset = 1'b0;
      waitCyc(3);
      chk("rst_code", oScanCode, 8'h00);
      chk("rst_break", oBreak, 0);
      chk("rst_ext", oExtended, 0);
      chk("rst_valid", oValid, 0);
      chk("rst_ferr", oFrameError, 0);
      Reset = 1'b1;
      waitCyc(20);

      v0 = nValid; e0 = nErr;
      sendFrame(8'h1C, 0, 0, 11, 0);
      waitDrain();
      chk("make_count", nValid - v0, 1);
      chk("make_code", oScanCode, 8'h1C);
      chk("make_brk", oBreak, 0);
      chk("make_ext", oExtended, 0);
      chk("make_noerr", nErr - e0, 0);
      chk("make_latency", lastValidCyc - lastLow, FL + 2);

      v0 = nValid;
      sendFrame(8'hE0, 0, 0, 11, 0);
      sendFrame(8'hF0, 0, 0, 11, 0);
      sendFrame(8'h75, 0, 0, 11, 0);
      waitDrain();
      chk("pfx_count", nValid - v0, 1);
      chk("pfx_code", oScanCode, 8'h75);
      chk("pfx_ext", oExtended, 1);
      chk("pfx_brk", oBreak, 1);
      sendFrame(8'h1C, 0, 0, 11, 0);
      waitDrain();
      chk("pfx_clr_brk", oBreak, 0);
      chk("pfx_clr_ext", oExtended, 0);

      sendFrame(8'h75, 0, 0, 11, 0);
      v0 = nValid; e0 = nErr;
      sendFrame(8'h1C, 1, 0, 11, 0);
      waitDrain();
      if (PCHK) begin
         chk("par_err", nErr - e0, 1);
         chk("par_novalid", nValid - v0, 0);
         chk("par_hold", oScanCode, 8'h75);
      end else begin
         chk("par_noerr", nErr - e0, 0);
         chk("par_valid", nValid - v0, 1);
         chk("par_code", oScanCode, 8'h1C);
      end

      e0 = nErr;
      sendFrame(8'hE0, 0, 0, 11, 0);
      sendFrame(8'h00, 0, 0, 6, 0);
      waitDrain();
      chk("to_err", nErr - e0, 1);
      sendFrame(8'h29, 0, 0, 11, 0);
      waitDrain();
      chk("to_code", oScanCode, 8'h29);
      chk("to_ext_clr", oExtended, 0);

      v0 = nValid; e0 = nErr;
      for (int g = 0; g < 3; g++) begin
         ps2Clk = 1'b0; waitCyc(3); ps2Clk = 1'b1; waitCyc(20);
      end
      sendFrame(8'h1C, 0, 0, 11, 1);
      waitDrain();
      chk("gl_count", nValid - v0, 1);
      chk("gl_code", oScanCode, 8'h1C);
      chk("gl_noerr", nErr - e0, 0);

      e0 = nErr;
      sendBits(11'h7FF, 1, 0, 0);
      waitCyc(2 * TO);
      chk("idle_hi_noerr", nErr - e0, 0);

      sendFrame(8'hE0, 0, 0, 11, 0);
      sendBits({1'b1, 1'b1, 8'hA5, 1'b0}, 5, 0, 0);
      Reset = 1'b0;
      #1;
      expQ.delete();
      mCode = 8'h00; mBrk = 0; mExt = 0; pendE = 0; pendF = 0;
      chk("mrst_code", oScanCode, 8'h00);
      chk("mrst_brk", oBreak, 0);
      chk("mrst_ext", oExtended, 0);
      chk("mrst_valid", oValid, 0);
      waitCyc(2);
      Reset = 1'b1;
      waitCyc(20);
      v0 = nValid; e0 = nErr;
      sendFrame(8'h5A, 0, 0, 11, 0);
      waitDrain();
      chk("mrst_next_count", nValid - v0, 1);
      chk("mrst_next_code", oScanCode, 8'h5A);
      chk("mrst_next_ext", oExtended, 0);
      chk("mrst_next_noerr", nErr - e0, 0);

      for (int i = 0; i < 40; i++) begin
         sel  = $urandom_range(0, 9);
         kind = $urandom_range(0, 9);
         b    = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
         case (kind)
            0: sendFrame(b, 0, 1, 11, 0);
            1: sendFrame(b, 1, 0, 11, 0);
            2: begin
               nb = $urandom_range(1, 10);
               sendFrame(b, 0, 0, nb, 0);
            end
            default: sendFrame(b, 0, 0, 11, (kind == 9));
         endcase
      end
      waitDrain();
      waitCyc(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Front-end PS/2 keyboard receiver that sits directly upstream of the keyboard-to-ALU path. It glitch-filters the raw PS2_CLK/PS2_DATA pins in the system clock domain and deframes 11-bit device-to-host frames. It folds the E0 (extended) and F0 (break) prefixes into flags, then presents one complete key event per one-cycle `oValid` pulse. The key-event consumer (position/command logic feeding the MiniAlu datapath) runs synchronously on `oValid` and never touches PS/2 pins or PS/2 clock edges.

## Interface
- `FILTER_LEN`, 8: filter shift-register depth in `Clock` cycles (range 2..16).
- `TIMEOUT_CYCLES`, 25000: maximum `Clock` cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 25 MHz).
- `Clock`  in  1  system clock (25 MHz domain).
- `Reset`  in  1  asynchronous, active-low reset.
- `iPS2_CLK`  in  1  raw PS/2 clock pin, asynchronous.
- `iPS2_DATA`  in  1  raw PS/2 data pin, asynchronous.
- `oScanCode`  out  8  last completed scan code (prefixes stripped).
- `oBreak`  out  1  high if `oScanCode` was preceded by F0.
- `oExtended`  out  1  high if `oScanCode` was preceded by E0.
- `oValid`  out  1  one-cycle pulse when a new key event is presented.
- `oFrameError`  out  1  one-cycle pulse on a framing, parity or timeout error.

## Operation
- **Filters (clock and data, identical):**
  - Each pin feeds a FILTER_LEN-bit shift register.
  - Filtered level goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - Reset value of the filtered level is 1.
- **Edge detect:** the falling-edge event `fall` = registered previous filtered clock AND NOT current filtered clock. It is asserted for exactly one cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. All transitions occur only on `fall` or on timeout.
  - IDLE: on `fall` with filtered data = 0 (start bit), go to DATA and clear the bit counter. On `fall` with data = 1, stay in IDLE with no error.
  - DATA: shift data in LSB first and increment the 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: frame is good if stop = 1 and data+parity has odd total ones. Good frame goes to the byte handler; otherwise pulse `oFrameError`. Return to IDLE in both cases.
- **Timeout:**
  - In any state other than IDLE, a counter clears on every `fall` and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1, force IDLE and pulse `oFrameError`.
- **Byte handler:**
  - E0 sets `ext_pend` and produces no output.
  - F0 sets `brk_pend` and produces no output.
  - Any other byte loads `oScanCode` with the byte, `oBreak` with `brk_pend` and `oExtended` with `ext_pend`, pulses `oValid`, and clears both pending flags.
- **Errors:** any `oFrameError` clears both pending flags.
- **Output hold:** `oScanCode`, `oBreak` and `oExtended` hold their values until the next `oValid`.
- **Reset (asynchronous, Reset = 0):**
  - FSM goes to IDLE; counters and pending flags clear.
  - `oScanCode` = 0x00; `oBreak`, `oExtended`, `oValid`, `oFrameError` = 0.
  - Filtered levels go to 1 and filter registers to all ones.
  - Reset applied mid-frame discards the partial frame. The first frame after release is decoded normally.

## Timing
- A raw clock low that is stable for FILTER_LEN cycles produces `fall` FILTER_LEN+1 cycles after the first low sample.
- `oValid` and `oFrameError` are registered. Each is high for exactly the one cycle after the `Clock` edge on which the stop-bit `fall` (or the timeout) is evaluated.
- `oScanCode`, `oBreak` and `oExtended` change on the same edge that raises `oValid`.
- Consecutive `oValid` pulses are at least one PS/2 bit time apart. No back-pressure: the consumer must accept on the pulse.
- If timeout and `fall` coincide, `fall` wins: the counter clears and no error is raised.
- Data is sampled from the filtered data level on the `fall` cycle. Filter delays on clock and data are equal, so setup relative to the PS/2 clock is preserved.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity mismatch in STOP is an error (`oFrameError`, no byte).
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled but ignored. Only the stop bit and the timeout can raise `oFrameError`.

## Test plan
- **Make code:** frame 0x1C (start 0, data 0,0,1,1,1,0,0,0 LSB first, parity 0, stop 1), 12.5 kHz PS/2 clock -> one `oValid` pulse, `oScanCode`=0x1C, `oBreak`=0, `oExtended`=0, `oFrameError` never high.
- **Prefixes:** frames E0, F0, 75 -> exactly one `oValid`, on the third frame: `oScanCode`=0x75, `oExtended`=1, `oBreak`=1. A following 0x1C -> `oBreak`=0, `oExtended`=0.
- **Parity:** 0x1C with parity bit 1.
  - Macro defined -> `oFrameError` pulse, no `oValid`, outputs unchanged.
  - Macro undefined -> `oValid` with 0x1C.
- **Timeout:** start plus 5 data bits, then clock held high for 30000 cycles -> `oFrameError` pulse at the TIMEOUT_CYCLES boundary. A following full 0x29 frame -> `oValid`, `oScanCode`=0x29.
- **Glitch rejection:** 3-cycle low pulses on `iPS2_CLK` in IDLE and mid-frame (FILTER_LEN=8) -> no bit shifted. A subsequent clean 0x1C decodes correctly.
- **Reset mid-frame:** Reset=0 for 2 cycles after the 4th data bit of a frame -> all outputs 0 immediately. The next full 0x5A frame -> `oValid`, `oScanCode`=0x5A, no error.
